// File: rtl/alu16_seq.sv
// Two-cycle sequencer running 16-bit DAD/INX/DCX through the 8-bit 8080 ALU.
// Define ALU16_SEQ_ZERO_EN to build the registered 16-bit zero flag on out_z.
module alu16_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_dad,
    input  logic        op_inx,
    input  logic        op_dcx,
    input  logic [15:0] in_hl,
    input  logic [15:0] in_rp,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_dst,
    output logic        alu_c,
    output logic        alu_op_add,
    output logic        alu_op_adc,
    output logic        alu_op_sbc,
    input  logic [7:0]  alu_out,
    input  logic        alu_out_c,
    output logic [15:0] out,
    output logic        out_c,
    output logic        out_c_we,
    output logic        out_z,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_DAD,
        K_INX,
        K_DCX
    } kind_t;

    state_t      state;
    state_t      state_nxt;
    kind_t       kind_q;
    kind_t       kind_sel;
    logic        op_valid;
    logic        accept;
    logic [15:0] hl_q;
    logic [15:0] rp_q;
    logic        carry_q;
    logic        is_dad;
    logic        is_hi;

    always_comb begin
        kind_sel = K_DAD;
        op_valid = 1'b0;
        priority case (1'b1)
            op_dad: begin
                kind_sel = K_DAD;
                op_valid = 1'b1;
            end
            op_inx: begin
                kind_sel = K_INX;
                op_valid = 1'b1;
            end
            op_dcx: begin
                kind_sel = K_DCX;
                op_valid = 1'b1;
            end
            default: begin
                kind_sel = K_DAD;
                op_valid = 1'b0;
            end
        endcase
    end

    assign accept = (state == S_IDLE) && start && op_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = accept ? S_LOW : S_IDLE;
            S_LOW:   state_nxt = S_HIGH;
            S_HIGH:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q <= K_DAD;
            hl_q   <= 16'h0000;
            rp_q   <= 16'h0000;
        end else if (accept) begin
            kind_q <= kind_sel;
            hl_q   <= in_hl;
            rp_q   <= in_rp;
        end
    end

    // Low byte lands first; carry_q chains its carry/borrow into the high byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            out     <= 16'h0000;
            out_c   <= 1'b0;
            carry_q <= 1'b0;
        end else if (state == S_LOW) begin
            out[7:0] <= alu_out;
            carry_q  <= alu_out_c;
        end else if (state == S_HIGH) begin
            out[15:8] <= alu_out;
            out_c     <= alu_out_c;
        end
    end

`ifdef ALU16_SEQ_ZERO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out_z <= 1'b0;
        end else if (state == S_HIGH) begin
            out_z <= ({alu_out, out[7:0]} == 16'h0000);
        end
    end
`else
    assign out_z = 1'b0;
`endif

    assign is_dad = (kind_q == K_DAD);
    assign is_hi  = (state == S_HIGH);

    // INX/DCX inject the +/-1 as the low-byte carry-in against a zero dst.
    always_comb begin
        alu_a      = 8'h00;
        alu_dst    = 8'h00;
        alu_c      = 1'b0;
        alu_op_add = 1'b0;
        alu_op_adc = 1'b0;
        alu_op_sbc = 1'b0;
        if (state == S_LOW || state == S_HIGH) begin
            if (is_dad) begin
                alu_a      = is_hi ? hl_q[15:8] : hl_q[7:0];
                alu_dst    = is_hi ? rp_q[15:8] : rp_q[7:0];
                alu_c      = is_hi ? carry_q : 1'b0;
                alu_op_add = !is_hi;
                alu_op_adc = is_hi;
            end else begin
                alu_a      = is_hi ? rp_q[15:8] : rp_q[7:0];
                alu_c      = is_hi ? carry_q : 1'b1;
                alu_op_adc = (kind_q == K_INX);
                alu_op_sbc = (kind_q == K_DCX);
            end
        end
    end

    assign busy     = (state == S_LOW) || (state == S_HIGH);
    assign done     = (state == S_DONE);
    assign out_c_we = (state == S_DONE) && is_dad;

endmodule

// File: tb/tb_alu16_seq.sv
// Directed bench for alu16_seq with a behavioural 8-bit 8080 ALU on the bus.
module tb_alu16_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op_dad;
    logic        op_inx;
    logic        op_dcx;
    logic [15:0] in_hl;
    logic [15:0] in_rp;
    logic [7:0]  alu_a;
    logic [7:0]  alu_dst;
    logic        alu_c;
    logic        alu_op_add;
    logic        alu_op_adc;
    logic        alu_op_sbc;
    logic [7:0]  alu_out;
    logic        alu_out_c;
    logic [15:0] out;
    logic        out_c;
    logic        out_c_we;
    logic        out_z;
    logic        busy;
    logic        done;

    logic [8:0]  alu_sum;
    int          checks;
    int          failures;
    int          lat;
    int          busy_cnt;
    int          done_cnt;
    logic        low_add;
    logic        low_c;
    logic        high_adc;
    logic        high_c;

    alu16_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_dad     (op_dad),
        .op_inx     (op_inx),
        .op_dcx     (op_dcx),
        .in_hl      (in_hl),
        .in_rp      (in_rp),
        .alu_a      (alu_a),
        .alu_dst    (alu_dst),
        .alu_c      (alu_c),
        .alu_op_add (alu_op_add),
        .alu_op_adc (alu_op_adc),
        .alu_op_sbc (alu_op_sbc),
        .alu_out    (alu_out),
        .alu_out_c  (alu_out_c),
        .out        (out),
        .out_c      (out_c),
        .out_c_we   (out_c_we),
        .out_z      (out_z),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_sum = 9'd0;
        if (alu_op_add)
            alu_sum = {1'b0, alu_a} + {1'b0, alu_dst};
        else if (alu_op_adc)
            alu_sum = {1'b0, alu_a} + {1'b0, alu_dst} + {8'd0, alu_c};
        else if (alu_op_sbc)
            alu_sum = {1'b0, alu_a} - {1'b0, alu_dst} - {8'd0, alu_c};
        alu_out   = alu_sum[7:0];
        alu_out_c = alu_sum[8];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Operands are scrambled right after accept to prove they were latched.
    task automatic run_op(input logic d, input logic i, input logic x,
                          input logic [15:0] hl, input logic [15:0] rp);
        @(negedge clk);
        op_dad = d;
        op_inx = i;
        op_dcx = x;
        in_hl  = hl;
        in_rp  = rp;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        op_dad   = 1'b0;
        op_inx   = 1'b0;
        op_dcx   = 1'b0;
        in_hl    = ~hl;
        in_rp    = ~rp;
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        low_add  = alu_op_add;
        low_c    = alu_c;
        high_adc = 1'b0;
        high_c   = 1'b0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (busy)
                busy_cnt++;
            if (lat == 2) begin
                high_adc = alu_op_adc;
                high_c   = alu_c;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op_dad   = 1'b0;
        op_inx   = 1'b0;
        op_dcx   = 1'b0;
        in_hl    = 16'h0000;
        in_rp    = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out), 32'h0000);
        chk("rst_flags", {27'd0, out_c, out_c_we, out_z, busy, done}, 32'h0);
        chk("rst_alu", {12'd0, alu_a, alu_dst, alu_c, alu_op_add,
            alu_op_adc, alu_op_sbc}, 32'h0);
        reset = 1'b0;

        run_op(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0FCD);
        chk("dad1_lat", 32'(lat), 32'd3);
        chk("dad1_out", 32'(out), 32'h2201);
        chk("dad1_c", 32'(out_c), 32'h0);
        chk("dad1_we", 32'(out_c_we), 32'h1);
        chk("dad1_busy", 32'(busy_cnt), 32'd2);
        chk("dad1_low", {30'd0, low_add, low_c}, 32'h2);
        chk("dad1_high", {30'd0, high_adc, high_c}, 32'h3);
        @(negedge clk);
        chk("dad1_pulse", {30'd0, done, out_c_we}, 32'h0);
        chk("dad1_hold", 32'(out), 32'h2201);

        run_op(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        chk("dad2_out", 32'(out), 32'h0000);
        chk("dad2_c", 32'(out_c), 32'h1);
        chk("dad2_we", 32'(out_c_we), 32'h1);
`ifdef ALU16_SEQ_ZERO_EN
        chk("dad2_z", 32'(out_z), 32'h1);
`else
        chk("dad2_z", 32'(out_z), 32'h0);
`endif

        run_op(1'b0, 1'b1, 1'b0, 16'h5555, 16'h00FF);
        chk("inx1_out", 32'(out), 32'h0100);
        chk("inx1_we", 32'(out_c_we), 32'h0);
        chk("inx1_z", 32'(out_z), 32'h0);
        run_op(1'b0, 1'b1, 1'b0, 16'h5555, 16'hFFFF);
        chk("inx2_out", 32'(out), 32'h0000);

        run_op(1'b0, 1'b0, 1'b1, 16'h5555, 16'h0000);
        chk("dcx1_out", 32'(out), 32'hFFFF);
        chk("dcx1_we", 32'(out_c_we), 32'h0);
        run_op(1'b0, 1'b0, 1'b1, 16'h5555, 16'h0100);
        chk("dcx2_out", 32'(out), 32'h00FF);
        run_op(1'b1, 1'b1, 1'b1, 16'h0100, 16'h0200);
        chk("prio_out", 32'(out), 32'h0300);

        @(negedge clk);
        op_dad = 1'b1;
        in_hl  = 16'h1234;
        in_rp  = 16'h0FCD;
        start  = 1'b1;
        @(negedge clk);
        op_dad = 1'b0;
        op_inx = 1'b1;
        in_rp  = 16'h0010;
        @(negedge clk);
        start    = 1'b0;
        op_inx   = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (done)
                done_cnt++;
            @(negedge clk);
        end
        chk("dbl_dones", 32'(done_cnt), 32'd1);
        chk("dbl_out", 32'(out), 32'h2201);

        start    = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy)
                busy_cnt++;
        end
        start = 1'b0;
        chk("noop_busy", 32'(busy_cnt), 32'd0);

        op_inx = 1'b1;
        in_rp  = 16'h00FF;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        op_inx = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_flags", {30'd0, busy, done}, 32'h0);
        chk("abort_out", 32'(out), 32'h0000);
        chk("abort_alu", {12'd0, alu_a, alu_dst, alu_c, alu_op_add,
            alu_op_adc, alu_op_sbc}, 32'h0);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done)
                done_cnt++;
        end
        chk("abort_nodone", 32'(done_cnt), 32'd0);

        run_op(1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234);
        chk("post_lat", 32'(lat), 32'd3);
        chk("post_out", 32'(out), 32'h1235);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
